fifo_v4: RTL
============

# fifo_v4

Parametrised synchronous FIFO with ready/valid handshakes on both sides, a full-width occupancy count, runtime-programmable almost-full/almost-empty thresholds, optional fall-through and an optional peak-occupancy watermark. It replaces push/pop-style FIFOs wherever a stream needs elastic buffering, for example between AXI channel decode and APB sequencing in the bridge. Arbitrary depths are supported, including non-powers of two.

## Interface
- DATA_WIDTH, 32, payload width in bits
- DEPTH, 8, number of entries; legal range 2..2**16
- FALL_THROUGH, 1'b0, when 1 an empty FIFO forwards input to output in the same cycle
- CNT_W, $clog2(DEPTH+1), derived width of the count; never overridden
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- flush_i  in  1  synchronous clear of all entries
- in_data_i  in  DATA_WIDTH  write payload
- in_valid_i  in  1  write request
- in_ready_o  out  1  space available; equals !full_o
- out_data_o  out  DATA_WIDTH  head payload; valid only while out_valid_o
- out_valid_o  out  1  head entry present
- out_ready_i  in  1  consumer accepts the head
- af_thresh_i  in  CNT_W  almost-full level
- ae_thresh_i  in  CNT_W  almost-empty level
- usage_o  out  CNT_W  current occupancy, 0..DEPTH
- full_o, empty_o, almost_full_o, almost_empty_o  out  1 each  status flags
- wm_clr_i  in  1  clear watermark (only with FIFO_V4_WATERMARK_EN)
- max_usage_o  out  CNT_W  peak occupancy (only with FIFO_V4_WATERMARK_EN)

## Operation
- Write fires when in_valid_i & in_ready_o; read fires when out_valid_o & out_ready_i.
- Pointers wrap from DEPTH-1 to 0 explicitly; never rely on power-of-2 rollover.
- Count update per cycle: write only +1, read only -1, both 0.
- full_o = (usage_o == DEPTH); empty_o = (usage_o == 0); almost_full_o = (usage_o >= af_thresh_i); almost_empty_o = (usage_o <= ae_thresh_i).
- out_valid_o = !empty_o, or, with FALL_THROUGH=1, !empty_o | in_valid_i.
- Full with a simultaneous read: in_ready_o stays 0. No write that cycle; in_ready_o has no combinational path from out_ready_i.
- Fall-through bypass: when empty and FALL_THROUGH=1, out_data_o = in_data_i.
  - If the bypass beat is read the same cycle, count and pointers are unchanged.
  - If it is not read, it is stored normally.
- flush_i has priority over write and read in the same cycle. Next cycle: count 0, pointers 0, and any beat accepted during the flush cycle is discarded.
- Memory contents are not reset; only pointers, count and watermark are.
- Reset values: usage_o 0, empty_o 1, full_o 0, in_ready_o 1, out_valid_o 0, almost_empty_o 1 when ae_thresh_i >= 0 (always 1), almost_full_o = (af_thresh_i == 0), max_usage_o 0.
- Reset asserted mid-transfer returns the block to those values immediately.

## Timing
- Non-fall-through: a beat written in cycle N appears on out_valid_o/out_data_o in cycle N+1.
- Fall-through: zero latency when empty; otherwise N+1.
- usage_o and all status flags are registered-derived and change the cycle after the causing handshake.
- Throughput: 1 beat/cycle sustained at any occupancy 1..DEPTH-1.
- Threshold inputs are sampled combinationally; any change takes effect on the flags in the same cycle.

## Configuration
- FIFO_V4_WATERMARK_EN defined:
  - max_usage_o holds the maximum usage_o value seen since reset, flush_i or wm_clr_i.
  - It updates one cycle after usage_o.
  - wm_clr_i loads the current usage_o.
- Undefined: no watermark register; max_usage_o is tied to 0 and wm_clr_i is ignored.

## Structure
- Shared package fifo_pkg:
  - fifo_status_t packed struct {full, empty, almost_full, almost_empty}, used internally and by integrators to bundle flags.
  - Function next_ptr(ptr, depth) for the wrap rule.
- Natural sub-module fifo_ptr_ctr: a modulo-DEPTH pointer with increment enable and synchronous clear. The block instantiates it twice (read and write).

## Test plan
- DEPTH=4, DATA_WIDTH=8: write 0x11,0x22,0x33,0x44 with out_ready_i=0 -> full_o=1, in_ready_o=0, usage_o=4. Then drain -> out_data_o sequence 0x11..0x44, empty_o=1.
- DEPTH=3 (non-power-of-2): 10 back-to-back writes and reads with both valid and ready held high -> data in order, usage_o steady at 1, pointers wrap 2->0.
- FALL_THROUGH=1, empty, in_valid_i=1 with 0xA5 and out_ready_i=1 -> out_data_o=0xA5 in the same cycle, usage_o stays 0.
- DEPTH=8, af_thresh_i=6, ae_thresh_i=1: fill to 6 -> almost_full_o asserts the cycle after the 6th write; almost_empty_o deasserts after the 2nd write.
- Occupancy 3 plus a write during flush_i -> next cycle usage_o=0, out_valid_o=0, and the flushed beat is never output. Repeat with rst_ni pulsed low mid-burst -> reset values are reached asynchronously.
- With FIFO_V4_WATERMARK_EN: fill to 5, drain to 1 -> max_usage_o=5. Then wm_clr_i -> max_usage_o=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_v4 family.
//   fifo_status_t : bundle of the four occupancy status flags.
//   next_ptr      : modulo-depth pointer advance; wraps explicitly so that
//                   non-power-of-two depths work.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointer -> 0)
//   clr_i         : synchronous clear, dominates inc_i
//   inc_i         : advance pointer by one, wrapping DEPTH-1 -> 0
//   ptr_o         : current pointer value
module fifo_ptr_ctr
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = PTR_W'(next_ptr(int'(ptr_q), DEPTH));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_v4.sv
// Synchronous ready/valid FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and optional fall-through.
// Optional peak-occupancy watermark when FIFO_V4_WATERMARK_EN is defined;
// otherwise max_usage_o is tied to 0 and wm_clr_i is ignored.
// Ports:
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   flush_i                    : synchronous clear, beats accepted this cycle are dropped
//   in_data_i/valid_i/ready_o  : write side handshake (in_ready_o = !full_o)
//   out_data_o/valid_o/ready_i : read side handshake
//   af_thresh_i, ae_thresh_i   : almost-full / almost-empty levels (combinational)
//   usage_o                    : occupancy 0..DEPTH
//   full_o, empty_o, almost_full_o, almost_empty_o : status flags
//   wm_clr_i, max_usage_o      : watermark clear / peak occupancy
module fifo_v4
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  input  logic [CNT_W-1:0]      af_thresh_i,
  input  logic [CNT_W-1:0]      ae_thresh_i,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic                  wm_clr_i,
  output logic [CNT_W-1:0]      max_usage_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      usage_q, usage_d;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  fifo_status_t          status;
  logic                  wr_fire, rd_fire, push, pop;

  always_comb begin
    status.full         = (usage_q == CNT_W'(DEPTH));
    status.empty        = (usage_q == '0);
    status.almost_full  = (usage_q >= af_thresh_i);
    status.almost_empty = (usage_q <= ae_thresh_i);
  end

  // in_ready_o depends only on registered state, never on out_ready_i.
  assign in_ready_o  = !status.full;
  assign out_valid_o = !status.empty | (FALL_THROUGH & in_valid_i);
  assign wr_fire     = in_valid_i & in_ready_o;
  assign rd_fire     = out_valid_o & out_ready_i;

  // A read while empty can only be the fall-through beat: it bypasses storage.
  assign push = wr_fire & ~(status.empty & rd_fire) & ~flush_i;
  assign pop  = rd_fire & ~status.empty & ~flush_i;

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (flush_i),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (flush_i),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    usage_d = usage_q;
    if (flush_i) begin
      usage_d = '0;
    end else if (push && !pop) begin
      usage_d = usage_q + 1'b1;
    end else if (pop && !push) begin
      usage_d = usage_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      usage_q <= '0;
    end else begin
      usage_q <= usage_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data_i;
    end
  end

  assign out_data_o     = (FALL_THROUGH && status.empty) ? in_data_i : mem_q[rd_ptr];
  assign usage_o        = usage_q;
  assign full_o         = status.full;
  assign empty_o        = status.empty;
  assign almost_full_o  = status.almost_full;
  assign almost_empty_o = status.almost_empty;

`ifdef FIFO_V4_WATERMARK_EN
  logic [CNT_W-1:0] max_q;

  // Tracks the registered occupancy, so it lags usage_o by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= '0;
    end else if (flush_i) begin
      max_q <= '0;
    end else if (wm_clr_i) begin
      max_q <= usage_q;
    end else if (usage_q > max_q) begin
      max_q <= usage_q;
    end
  end

  assign max_usage_o = max_q;
`else
  logic unused_wm_clr;
  assign unused_wm_clr = wm_clr_i;
  assign max_usage_o   = '0;
`endif

endmodule
